// File: rtl/gcn_transform_ctrl_if.sv
// Handshake and memory-read bundle between the GCN transform sequencer and its
// memory, weight/feature buffers, dot-product datapath and result buffer.
interface gcn_transform_ctrl_if #(
  parameter int ADDRESS_WIDTH         = 13,
  parameter int COUNTER_FEATURE_WIDTH = 3,
  parameter int COUNTER_WEIGHT_WIDTH  = 2
);
  logic                             start;
  logic [ADDRESS_WIDTH-1:0]         read_address;
  logic                             enable_read;
  logic                             weight_load_en;
  logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_load_idx;
  logic                             feature_load_en;
  logic                             dp_start;
  logic [COUNTER_WEIGHT_WIDTH-1:0]  dp_col;
  logic                             dp_valid;
  logic                             wr_en;
  logic [COUNTER_FEATURE_WIDTH-1:0] wr_row;
  logic [COUNTER_WEIGHT_WIDTH-1:0]  wr_col;
  logic                             done;

  modport master (
    input  start, dp_valid,
    output read_address, enable_read, weight_load_en, weight_load_idx,
           feature_load_en, dp_start, dp_col, wr_en, wr_row, wr_col, done
  );

  modport slave (
    output start, dp_valid,
    input  read_address, enable_read, weight_load_en, weight_load_idx,
           feature_load_en, dp_start, dp_col, wr_en, wr_row, wr_col, done
  );
endinterface

// File: rtl/gcn_transform_ctrl.sv
// GCN transformation sequencer: loads weight columns and feature rows, then runs
// one dot-product per (row, col) pair and writes each result to the FM_WM buffer.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start
// S_LOAD_W  | reading weight column w
// S_LOAD_F  | reading feature row f
// S_CAPT_F  | feature row data valid, capture it
// S_DP_GO   | launch dot-product for column c
// S_DP_WAIT | waiting for dp_valid
// S_WRITE   | write result (f, c)
// S_DONE    | all results written, wait for start to drop
module gcn_transform_ctrl #(
  parameter int FEATURE_ROWS          = 6,
  parameter int WEIGHT_COLS           = 3,
  parameter int ADDRESS_WIDTH         = 13,
  parameter int FEATURE_BASE          = 512,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
  parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS)
) (
  input logic                  clk,
  input logic                  reset,
  gcn_transform_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_F, S_CAPT_F, S_DP_GO, S_DP_WAIT, S_WRITE, S_DONE
  } state_t;

  localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  W_LAST    = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);
  localparam logic [COUNTER_FEATURE_WIDTH-1:0] F_LAST    = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [ADDRESS_WIDTH-1:0]         BASE_ADDR = ADDRESS_WIDTH'(FEATURE_BASE);

  state_t                           state, state_nxt;
  logic [COUNTER_WEIGHT_WIDTH-1:0]  w, w_nxt, c, c_nxt;
  logic [COUNTER_FEATURE_WIDTH-1:0] f, f_nxt;
  logic [ADDRESS_WIDTH-1:0]         addr_q, addr_nxt;
  logic                             wl_en_q;
  logic [COUNTER_WEIGHT_WIDTH-1:0]  wl_idx_q;
  logic [COUNTER_WEIGHT_WIDTH-1:0]  w_inc, c_inc;
  logic [COUNTER_FEATURE_WIDTH-1:0] f_inc;

  assign w_inc = w + 1'b1;
  assign c_inc = c + 1'b1;
  assign f_inc = f + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      w        <= '0;
      f        <= '0;
      c        <= '0;
      addr_q   <= '0;
      wl_en_q  <= 1'b0;
      wl_idx_q <= '0;
    end else begin
      state    <= state_nxt;
      w        <= w_nxt;
      f        <= f_nxt;
      c        <= c_nxt;
      addr_q   <= addr_nxt;
      // read data arrives one cycle after the address, so the capture strobe lags LOAD_W
      wl_en_q  <= (state == S_LOAD_W);
      if (state == S_LOAD_W) wl_idx_q <= w;
    end
  end

  always_comb begin
    state_nxt = state;
    w_nxt     = w;
    f_nxt     = f;
    c_nxt     = c;
    addr_nxt  = addr_q;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_LOAD_W;
          w_nxt     = '0;
          f_nxt     = '0;
          c_nxt     = '0;
          addr_nxt  = '0;
        end
      end
      S_LOAD_W: begin
        if (w == W_LAST) begin
          state_nxt = S_LOAD_F;
          f_nxt     = '0;
          addr_nxt  = BASE_ADDR;
        end else begin
          w_nxt    = w_inc;
          addr_nxt = ADDRESS_WIDTH'(w_inc);
        end
      end
      S_LOAD_F: state_nxt = S_CAPT_F;
      S_CAPT_F: begin
        c_nxt     = '0;
        state_nxt = S_DP_GO;
      end
      S_DP_GO: state_nxt = S_DP_WAIT;
      S_DP_WAIT: begin
        if (bus.dp_valid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (c != W_LAST) begin
          c_nxt     = c_inc;
          state_nxt = S_DP_GO;
        end else if (f != F_LAST) begin
          f_nxt     = f_inc;
          addr_nxt  = BASE_ADDR + ADDRESS_WIDTH'(f_inc);
          state_nxt = S_LOAD_F;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.enable_read     = (state == S_LOAD_W) || (state == S_LOAD_F);
  assign bus.read_address    = addr_q;
  assign bus.weight_load_en  = wl_en_q;
  assign bus.weight_load_idx = wl_idx_q;
  assign bus.feature_load_en = (state == S_CAPT_F);
  assign bus.dp_start        = (state == S_DP_GO);
  assign bus.dp_col          = c;
  assign bus.wr_en           = (state == S_WRITE);
  assign bus.wr_row          = f;
  assign bus.wr_col          = c;
  assign bus.done            = (state == S_DONE);
endmodule
